imem_boot_loader: RTL
=====================

Name: imem_boot_loader

Overview:
- Upstream feeder for the single-cycle RISC_V core; it fills instruction memory before execution starts.
- Accepts a byte stream through a valid/ready handshake and packs bytes little-endian into 32-bit words.
- Writes each word through the iMem write port, then releases core reset after a fixed delay.
- Replaces the bench-only hex preload with a synthesizable boot path.

Parameters:
- IMEM_DEPTH, 256, instruction memory size in 32-bit words.
- ADDR_W, 32, width of the iMem byte address.
- RELEASE_DELAY, 2, clock cycles between the final word write and core_rstn rising; range 1..15.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  byte available on in_data.
- in_data  in  8  stream byte.
- in_last  in  1  marks the final byte of the program; qualified by in_valid.
- in_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  one-cycle iMem write strobe.
- imem_addr  out  ADDR_W  iMem byte address, always a multiple of 4.
- imem_wdata  out  32  word to write.
- core_rstn  out  1  active-low reset to the core; registered.
- done  out  1  program loaded and core released.
- error  out  1  overflow detected; sticky until rstn.

Behaviour:
- Reset (async, rstn=0): state=LOAD, byte_cnt=0, word_idx=0, all outputs 0 (core_rstn=0, in_ready=0). in_ready goes to 1 on the first clock after rstn deasserts.
- Handshake: a byte is accepted when in_valid && in_ready. in_data and in_last are ignored otherwise. in_ready is combinational from state only, never from in_valid.
- Packing: byte k of a word (k=0..3) goes to bits [8k+7:8k]. The first accepted byte lands in [7:0].
- LOAD:
  - in_ready=1.
  - On the 4th accepted byte, or on an accepted byte with in_last=1: the registered write fires next cycle with imem_we=1, imem_addr=word_idx*4, imem_wdata=packed word. Unfilled upper bytes are zero.
  - word_idx increments with each write; byte_cnt clears.
  - in_last → HOLD.
  - If a byte is accepted while word_idx==IMEM_DEPTH → ERROR; no write occurs.
- HOLD:
  - in_ready=0.
  - A counter loads RELEASE_DELAY on the cycle the last write is issued and decrements each cycle.
  - When it reaches 0, core_rstn←1 and done←1 → RUN.
  - With RELEASE_DELAY=2, core_rstn rises exactly 2 cycles after the imem_we cycle of the final word.
- RUN:
  - in_ready=0 and in_valid is ignored.
  - core_rstn=1 and done=1 are held.
  - Only rstn restarts a load.
- ERROR: in_ready=0, error=1, core_rstn=0; terminal until rstn.
- Write strobe: imem_we is high for exactly one cycle per word. imem_addr and imem_wdata hold their last value when imem_we=0.
- Back-to-back bytes are accepted every cycle with no bubble. A write from word N and acceptance of word N+1 byte 0 may coincide.
- Reset mid-load: partial word discarded, word_idx=0, core_rstn returns low asynchronously. Previously written iMem contents are not cleared.
- Addresses use no wrap; overflow is the ERROR path.

Optional Feature:
- Macro: BOOT_CHECKSUM_EN.
- Defined:
  - Extra ports exp_sum (in, 32) and sum_ok (out, 1).
  - A 32-bit modulo-2^32 additive sum accumulates every written word, including the padded final word.
  - On entering HOLD, the sum is compared to exp_sum.
  - Mismatch → ERROR, with core_rstn kept low. Match → sum_ok=1, then HOLD proceeds normally.
  - sum_ok resets to 0.
- Not defined: no extra ports or logic; HOLD always proceeds.

Decomposition:
- Package boot_pkg holds:
  - state encoding typedef (LOAD, HOLD, RUN, ERROR);
  - BYTES_PER_WORD=4;
  - the default RELEASE_DELAY constant.
- One sub-module, boot_word_packer: byte_cnt plus shift/pack register. It emits word_valid and word with zero-padding on last.
- FSM, address counter, delay counter and checksum stay in the top.

Test Plan:
- Bytes 00..07 streamed continuously, last on 07 → writes 0x03020100@0x0 then 0x07060504@0x4; core_rstn=1 two cycles after the second imem_we; done=1.
- 5 bytes 11,22,33,44,55, last on 55 → 0x44332211@0x0, 0x00000055@0x4; exactly 2 imem_we pulses.
- Same 8 bytes with in_valid toggling 1-0-1 and random gaps → identical writes; no byte lost or duplicated.
- IMEM_DEPTH=2, 9 bytes → two writes, then error=1, in_ready=0, core_rstn stays 0, no third imem_we.
- rstn pulsed low after 6 bytes, then 4 bytes AA,BB,CC,DD with last → core_rstn drops immediately; single write 0xDDCCBBAA@0x0.
- BOOT_CHECKSUM_EN, bytes 00..07: exp_sum=0x0A080604 → sum_ok=1 and release. exp_sum=0 → ERROR, core_rstn=0.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared constants and FSM state encoding for the instruction-memory boot loader.
package boot_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StLoad  = 2'd0;
  localparam state_t StHold  = 2'd1;
  localparam state_t StRun   = 2'd2;
  localparam state_t StError = 2'd3;

  localparam int unsigned BYTES_PER_WORD        = 4;
  localparam int unsigned DEFAULT_RELEASE_DELAY = 2;

endpackage

// File: rtl/boot_word_packer.sv
// Packs accepted stream bytes little-endian into 32-bit words; flags a completed word
// on the 4th byte or on a byte marked last, zero-padding any unfilled upper bytes.
module boot_word_packer
  import boot_pkg::*;
(
  input  logic        clock,
  input  logic        rstn,
  input  logic        byte_acc,
  input  logic [7:0]  byte_data,
  input  logic        byte_last,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  byte_cnt_q, byte_cnt_d;
  // Bytes 0..2 of the word in progress; cleared after each word so padding is zero.
  logic [23:0] pack_q, pack_d;
  logic [31:0] merged;

  always_comb begin
    merged = {8'h00, pack_q};
    merged[{byte_cnt_q, 3'b000} +: 8] = byte_data;

    word_valid = byte_acc && ((byte_cnt_q == 2'(BYTES_PER_WORD - 1)) || byte_last);
    word       = merged;

    byte_cnt_d = byte_cnt_q;
    pack_d     = pack_q;
    if (byte_acc) begin
      if (word_valid) begin
        byte_cnt_d = 2'd0;
        pack_d     = 24'h0;
      end else begin
        byte_cnt_d = byte_cnt_q + 2'd1;
        pack_d     = merged[23:0];
      end
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      byte_cnt_q <= 2'd0;
      pack_q     <= 24'h0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      pack_q     <= pack_d;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: fills iMem from a byte stream, then releases core reset after a delay.
// Define BOOT_CHECKSUM_EN to gate the release on an additive checksum of written words.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH    = 256,
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned RELEASE_DELAY = DEFAULT_RELEASE_DELAY
) (
  input  logic              clock,
  input  logic              rstn,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
`ifdef BOOT_CHECKSUM_EN
  input  logic [31:0]       exp_sum,
  output logic              sum_ok,
`endif
  output logic              core_rstn,
  output logic              done,
  output logic              error
);

  localparam int unsigned IDX_W = $clog2(IMEM_DEPTH + 1);

  state_t             state_q, state_d;
  logic               armed_q;
  logic [IDX_W-1:0]   word_idx_q;
  logic [3:0]         dly_q;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        wdata_q;
  logic               core_rstn_q, done_q, error_q;

  logic               accept, full, overflow, pack_acc;
  logic               word_valid;
  logic [31:0]        word;
  logic               sum_match;

  // armed_q holds in_ready low for the first cycle out of reset.
  assign in_ready = armed_q && (state_q == StLoad);
  assign accept   = in_valid && in_ready;
  assign full     = (word_idx_q == IDX_W'(IMEM_DEPTH));
  assign overflow = accept && full;
  assign pack_acc = accept && !full;

  boot_word_packer u_packer (
    .clock      (clock),
    .rstn       (rstn),
    .byte_acc   (pack_acc),
    .byte_data  (in_data),
    .byte_last  (in_last),
    .word_valid (word_valid),
    .word       (word)
  );

`ifdef BOOT_CHECKSUM_EN
  logic [31:0] sum_q;
  logic        sum_ok_q;

  assign sum_match = (sum_q == exp_sum);
  assign sum_ok    = sum_ok_q;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      sum_q    <= 32'h0;
      sum_ok_q <= 1'b0;
    end else begin
      if (word_valid) sum_q <= sum_q + word;
      if ((state_q == StHold) && sum_match) sum_ok_q <= 1'b1;
    end
  end
`else
  assign sum_match = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad: begin
        if (overflow) begin
          state_d = StError;
        end else if (pack_acc && in_last) begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (!sum_match) begin
          state_d = StError;
        end else if (dly_q == 4'd1) begin
          state_d = StRun;
        end
      end
      StRun:   state_d = StRun;
      StError: state_d = StError;
    endcase
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StLoad;
      armed_q     <= 1'b0;
      dly_q       <= 4'd0;
      core_rstn_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      armed_q     <= 1'b1;
      core_rstn_q <= (state_d == StRun);
      done_q      <= (state_d == StRun);
      error_q     <= (state_d == StError);
      // Loaded alongside the final write; release happens as it would reach zero.
      if ((state_q == StLoad) && (state_d == StHold)) begin
        dly_q <= 4'(RELEASE_DELAY);
      end else if (state_q == StHold) begin
        dly_q <= dly_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      word_idx_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
    end else begin
      we_q <= word_valid;
      if (word_valid) begin
        addr_q     <= ADDR_W'({word_idx_q, 2'b00});
        wdata_q    <= word;
        word_idx_q <= word_idx_q + IDX_W'(1);
      end
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_rstn  = core_rstn_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule
